// File: rtl/encoder8_3_queue.sv
// Priority encoder with an 8-entry pending-event set and a one-deep valid/ready output stage.
// Optional ENCODER_MERGE_COUNT_EN adds a saturating count of edges where a request merged into a pending event.
module encoder8_3_queue #(
    parameter int unsigned LSB_FIRST = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       ready,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending
`ifdef ENCODER_MERGE_COUNT_EN
    ,
    output logic [3:0] merge_cnt
`endif
);

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t              r_state;
    logic [N_REQ-1:0]    r_pending;
    logic [CODE_W-1:0]   r_code;
    logic                r_valid;

    logic                w_load;
    logic                w_any;
    logic [CODE_W-1:0]   w_sel;
    logic [N_REQ-1:0]    w_take;

    // Highest-priority pending index; the last hit in scan order wins.
    always_comb begin
        logic [CODE_W-1:0] idx;
        w_sel = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (LSB_FIRST != 0) begin
                idx = CODE_W'(N_REQ - 1 - i);
            end else begin
                idx = CODE_W'(i);
            end
            if (r_pending[idx]) begin
                w_sel = idx;
            end
        end
    end

    assign w_load = (r_state == S_EMPTY) || ready;
    assign w_any  = |r_pending;
    assign w_take = (w_load && w_any) ? (N_REQ'(1) << w_sel) : '0;

    // Output FSM and pending set; a req on the bit being taken re-posts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_EMPTY;
            r_pending <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_take) | req;
            if (w_load) begin
                if (w_any) begin
                    r_code  <= w_sel;
                    r_valid <= 1'b1;
                    r_state <= S_FULL;
                end else begin
                    r_valid <= 1'b0;
                    r_state <= S_EMPTY;
                end
            end
        end
    end

    assign code    = r_code;
    assign valid   = r_valid;
    assign pending = r_pending;

`ifdef ENCODER_MERGE_COUNT_EN
    logic [CNT_W-1:0] r_merge_cnt;
    logic             w_merge;

    assign w_merge = |(req & r_pending & ~w_take);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_merge_cnt <= '0;
        end else if (w_merge && (r_merge_cnt != {CNT_W{1'b1}})) begin
            r_merge_cnt <= r_merge_cnt + CNT_W'(1);
        end
    end

    assign merge_cnt = r_merge_cnt;
`endif

endmodule

// File: tb/tb_encoder8_3_queue.sv
// Scoreboard bench for encoder8_3_queue: MSB-first and LSB-first instances driven in lockstep.
// Merge-count checks compile in only with ENCODER_MERGE_COUNT_EN.
module tb_encoder8_3_queue;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ready;
    logic [2:0] code_m, code_l;
    logic       valid_m, valid_l;
    logic [7:0] pending_m, pending_l;
`ifdef ENCODER_MERGE_COUNT_EN
    logic [3:0] merge_cnt_m, merge_cnt_l;
`endif

    int vectors;
    int miscompares;
    logic [2:0] q_m[$];
    logic [2:0] q_l[$];

    encoder8_3_queue #(.LSB_FIRST(0)) dut_m (
        .clk(clk), .rst(rst), .req(req), .ready(ready),
        .code(code_m), .valid(valid_m), .pending(pending_m)
`ifdef ENCODER_MERGE_COUNT_EN
        , .merge_cnt(merge_cnt_m)
`endif
    );

    encoder8_3_queue #(.LSB_FIRST(1)) dut_l (
        .clk(clk), .rst(rst), .req(req), .ready(ready),
        .code(code_l), .valid(valid_l), .pending(pending_l)
`ifdef ENCODER_MERGE_COUNT_EN
        , .merge_cnt(merge_cnt_l)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after posedge, so at negedge valid&&ready means acceptance at the next edge.
    always @(negedge clk) begin
        if (!rst && valid_m && ready) begin
            vectors++;
            if (q_m.size() == 0) begin
                miscompares++;
                $display("FAIL sb_msb unexpected accept code=%0d, queue empty", code_m);
            end else begin
                logic [2:0] exp_c;
                exp_c = q_m.pop_front();
                if (code_m !== exp_c) begin
                    miscompares++;
                    $display("FAIL sb_msb code=%0d expected %0d", code_m, exp_c);
                end
            end
        end
        if (!rst && valid_l && ready) begin
            vectors++;
            if (q_l.size() == 0) begin
                miscompares++;
                $display("FAIL sb_lsb unexpected accept code=%0d, queue empty", code_l);
            end else begin
                logic [2:0] exp_c;
                exp_c = q_l.pop_front();
                if (code_l !== exp_c) begin
                    miscompares++;
                    $display("FAIL sb_lsb code=%0d expected %0d", code_l, exp_c);
                end
            end
        end
    end

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'hFF; ready = 1'b1;
        #3;
        vectors++;
        if (pending_m !== 8'h00 || valid_m !== 1'b0 || code_m !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state pend=%h valid=%b code=%0d expected 00/0/0", pending_m, valid_m, code_m);
        end
        next_edge();
        vectors++;
        if (pending_m !== 8'h00 || pending_l !== 8'h00 || valid_l !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ignores_req pend_m=%h pend_l=%h valid_l=%b expected 00/00/0", pending_m, pending_l, valid_l);
        end
`ifdef ENCODER_MERGE_COUNT_EN
        vectors++;
        if (merge_cnt_m !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_merge_cnt got %0d expected 0", merge_cnt_m);
        end
`endif
        rst = 1'b0; req = 8'h00; ready = 1'b0;
        next_edge();
    endtask

    task automatic test_priority();
        req = 8'h24; ready = 1'b1;
        q_m.push_back(3'd5); q_m.push_back(3'd2);
        q_l.push_back(3'd2); q_l.push_back(3'd5);
        next_edge();
        req = 8'h00;
        vectors++;
        if (pending_m !== 8'h24 || valid_m !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_e1 pend=%h valid=%b expected 24/0", pending_m, valid_m);
        end
        next_edge();
        vectors++;
        if (code_m !== 3'd5 || valid_m !== 1'b1 || pending_m !== 8'h04 || code_l !== 3'd2 || pending_l !== 8'h20) begin
            miscompares++;
            $display("FAIL prio_e2 m:%0d/%b/%h l:%0d/%h expected m:5/1/04 l:2/20",
                     code_m, valid_m, pending_m, code_l, pending_l);
        end
        next_edge();
        vectors++;
        if (code_m !== 3'd2 || code_l !== 3'd5 || valid_m !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_e3 m=%0d l=%0d valid=%b expected 2/5/1", code_m, code_l, valid_m);
        end
        next_edge();
        vectors++;
        if (valid_m !== 1'b0 || valid_l !== 1'b0 || pending_m !== 8'h00 || code_m !== 3'd2) begin
            miscompares++;
            $display("FAIL prio_e4 valid=%b/%b pend=%h code=%0d expected 0/0/00/2", valid_m, valid_l, pending_m, code_m);
        end
    endtask

    task automatic test_hold();
        req = 8'h80; ready = 1'b0;
        q_m.push_back(3'd7); q_l.push_back(3'd7);
        next_edge();
        req = 8'h00;
        next_edge();
        vectors++;
        if (code_m !== 3'd7 || valid_m !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_load code=%0d valid=%b expected 7/1", code_m, valid_m);
        end
        req = 8'h01;
        q_m.push_back(3'd0); q_l.push_back(3'd0);
        for (int i = 0; i < 4; i++) begin
            next_edge();
            req = 8'h00;
            vectors++;
            if (code_m !== 3'd7 || valid_m !== 1'b1 || pending_m !== 8'h01 || code_l !== 3'd7) begin
                miscompares++;
                $display("FAIL hold_cyc%0d code=%0d/%0d valid=%b pend=%h expected 7/7/1/01",
                         i, code_m, code_l, valid_m, pending_m);
            end
        end
        ready = 1'b1;
        next_edge();
        vectors++;
        if (code_m !== 3'd0 || valid_m !== 1'b1 || pending_m !== 8'h00) begin
            miscompares++;
            $display("FAIL hold_release code=%0d valid=%b pend=%h expected 0/1/00", code_m, valid_m, pending_m);
        end
        next_edge();
        vectors++;
        if (valid_m !== 1'b0 || q_m.size() != 0 || q_l.size() != 0) begin
            miscompares++;
            $display("FAIL hold_drain valid=%b qm=%0d ql=%0d expected 0/0/0", valid_m, q_m.size(), q_l.size());
        end
    endtask

    task automatic test_take_collide();
        req = 8'h08; ready = 1'b1;
        q_m.push_back(3'd3); q_m.push_back(3'd3);
        q_l.push_back(3'd3); q_l.push_back(3'd3);
        next_edge();
        next_edge();
        req = 8'h00;
        vectors++;
        if (code_m !== 3'd3 || valid_m !== 1'b1 || pending_m !== 8'h08) begin
            miscompares++;
            $display("FAIL collide_keep code=%0d valid=%b pend=%h expected 3/1/08", code_m, valid_m, pending_m);
        end
        next_edge();
        vectors++;
        if (code_m !== 3'd3 || valid_m !== 1'b1 || pending_m !== 8'h00) begin
            miscompares++;
            $display("FAIL collide_again code=%0d valid=%b pend=%h expected 3/1/00", code_m, valid_m, pending_m);
        end
        next_edge();
        vectors++;
        if (valid_m !== 1'b0 || q_m.size() != 0) begin
            miscompares++;
            $display("FAIL collide_drain valid=%b qm=%0d expected 0/0", valid_m, q_m.size());
        end
`ifdef ENCODER_MERGE_COUNT_EN
        vectors++;
        if (merge_cnt_m !== 4'd0) begin
            miscompares++;
            $display("FAIL collide_no_merge merge_cnt=%0d expected 0", merge_cnt_m);
        end
`endif
    endtask

    task automatic test_merge();
        req = 8'h80; ready = 1'b0;
        q_m.push_back(3'd7); q_m.push_back(3'd4);
        q_l.push_back(3'd7); q_l.push_back(3'd4);
        next_edge();
        req = 8'h00;
        next_edge();
        req = 8'h10;
        for (int i = 0; i < 3; i++) next_edge();
        vectors++;
        if (pending_m !== 8'h10 || code_m !== 3'd7) begin
            miscompares++;
            $display("FAIL merge_pend pend=%h code=%0d expected 10/7", pending_m, code_m);
        end
`ifdef ENCODER_MERGE_COUNT_EN
        vectors++;
        if (merge_cnt_m !== 4'd2 || merge_cnt_l !== 4'd2) begin
            miscompares++;
            $display("FAIL merge_cnt2 got %0d/%0d expected 2", merge_cnt_m, merge_cnt_l);
        end
`endif
        for (int i = 0; i < 20; i++) next_edge();
`ifdef ENCODER_MERGE_COUNT_EN
        vectors++;
        if (merge_cnt_m !== 4'd15) begin
            miscompares++;
            $display("FAIL merge_sat got %0d expected 15", merge_cnt_m);
        end
`endif
        req = 8'h00; ready = 1'b1;
        next_edge();
        next_edge();
        next_edge();
        vectors++;
        if (valid_m !== 1'b0 || pending_m !== 8'h00 || q_m.size() != 0 || q_l.size() != 0) begin
            miscompares++;
            $display("FAIL merge_single valid=%b pend=%h qm=%0d ql=%0d expected 0/00/0/0",
                     valid_m, pending_m, q_m.size(), q_l.size());
        end
    endtask

    task automatic test_back_to_back();
        req = 8'hFF; ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q_m.push_back(3'(7 - i));
            q_l.push_back(3'(i));
        end
        next_edge();
        req = 8'h00;
        for (int i = 0; i < 8; i++) begin
            next_edge();
            vectors++;
            if (valid_m !== 1'b1 || valid_l !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_cyc%0d valid=%b/%b expected 1/1", i, valid_m, valid_l);
            end
        end
        next_edge();
        vectors++;
        if (valid_m !== 1'b0 || q_m.size() != 0 || q_l.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain valid=%b qm=%0d ql=%0d expected 0/0/0", valid_m, q_m.size(), q_l.size());
        end
    endtask

    task automatic test_async_reset();
        req = 8'hFF; ready = 1'b0;
        next_edge();
        next_edge();
        vectors++;
        if (pending_m !== 8'hFF || valid_m !== 1'b1 || code_m !== 3'd7 || code_l !== 3'd0) begin
            miscompares++;
            $display("FAIL areset_setup pend=%h valid=%b code=%0d/%0d expected FF/1/7/0",
                     pending_m, valid_m, code_m, code_l);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (pending_m !== 8'h00 || valid_m !== 1'b0 || code_m !== 3'd0 || pending_l !== 8'h00 || valid_l !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_async pend=%h/%h valid=%b/%b code=%0d expected 00/00/0/0/0",
                     pending_m, pending_l, valid_m, valid_l, code_m);
        end
        next_edge();
        vectors++;
        if (pending_m !== 8'h00 || valid_m !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_held pend=%h valid=%b expected 00/0", pending_m, valid_m);
        end
        rst = 1'b0; req = 8'h02; ready = 1'b1;
        q_m.push_back(3'd1); q_l.push_back(3'd1);
        next_edge();
        req = 8'h00;
        vectors++;
        if (pending_m !== 8'h02 || valid_m !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_first_edge pend=%h valid=%b expected 02/0", pending_m, valid_m);
        end
        next_edge();
        next_edge();
        vectors++;
        if (valid_m !== 1'b0 || q_m.size() != 0 || q_l.size() != 0) begin
            miscompares++;
            $display("FAIL areset_drain valid=%b qm=%0d ql=%0d expected 0/0/0", valid_m, q_m.size(), q_l.size());
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_priority();
        test_hold();
        test_take_collide();
        test_merge();
        test_back_to_back();
        test_async_reset();
        repeat (2) next_edge();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/encoder8_3_queue.md
ENCODER8_3_QUEUE -- requirements
Module: encoder8_3_queue

Interface
REQ-001 Parameter: LSB_FIRST, default 0; 0 = bit 7 highest priority, 1 = bit 0 highest priority.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  8  request strobes; each set bit posts one event for its index, sampled every clock edge.
REQ-005 ready  input  1  consumer accepts code this cycle when high together with valid.
REQ-006 code  output  3  binary index of the presented event; registered.
REQ-007 valid  output  1  code holds a presented event; registered.
REQ-008 pending  output  8  registered set of posted, not yet presented, events.

Function
REQ-009 Two-state output FSM: EMPTY (valid=0) and FULL (valid=1).
REQ-010 pending update each edge: pending <= (pending & ~take) | req, where take is the one-hot bit loaded into the output this edge, else 0.
REQ-011 Load condition: state EMPTY, or state FULL with ready=1; when load is true and pending != 0, the highest-priority pending bit is encoded into code, state becomes or stays FULL, and that bit is cleared via take.
REQ-012 Load true with pending == 0: state goes to EMPTY, valid=0, code holds its last value.
REQ-013 FULL with ready=0: code, valid hold; pending accumulates only.
REQ-014 Latency: req bit set before edge k with empty output and no other pending -> pending bit visible after edge k, valid=1 with matching code after edge k+1.
REQ-015 Throughput: with ready held high and pending nonempty, one event is presented per clock.
REQ-016 A req bit equal to the bit being taken in the same edge leaves that pending bit set (new event wins).
REQ-017 A req bit on an already-set pending bit merges into it; only one event is presented for it.
REQ-018 req is not qualified by ready; the block never back-pressures requests.
REQ-019 Priority follows LSB_FIRST for every load; ties among simultaneous req bits resolve the same way.
REQ-020 Output presented with valid=1 is stable until the cycle it is accepted.

Reset
REQ-021 rst=1 immediately forces pending=8'h00, code=3'b000, valid=0, state EMPTY, regardless of clk.
REQ-022 Reset mid-operation discards all pending and presented events; req sampled while rst=1 is ignored.
REQ-023 First edge after rst deasserts samples req normally.

Configuration
REQ-024 Macro ENCODER_MERGE_COUNT_EN: when defined, adds output merge_cnt (4 bits), reset 0, incremented once per edge in which any req bit merges per REQ-017 (excluding the REQ-016 case), saturating at 15.
REQ-025 Without ENCODER_MERGE_COUNT_EN the merge_cnt port and its logic do not exist; all other behaviour is identical.

Verification
REQ-026 Reset, req=8'h24, ready=1, LSB_FIRST=0 -> after edge 1 pending=8'h24; edge 2 code=5 valid=1 pending=8'h04; edge 3 code=2; edge 4 valid=0 pending=0.
REQ-027 Same stimulus, LSB_FIRST=1 -> codes presented in order 2 then 5.
REQ-028 FULL with code=7, ready=0 for 4 cycles, req=8'h01 one cycle -> code=7 held, pending=8'h01; ready=1 -> next edge code=0.
REQ-029 Bit 3 being taken while req=8'h08 same edge -> code=3 presented and pending bit 3 remains set; next accept presents code=3 again.
REQ-030 req=8'h10 on three consecutive edges while bit 4 pending and ready=0 -> single event for code 4; with ENCODER_MERGE_COUNT_EN merge_cnt=2 (after first sets, two merges), saturates at 15 under 20 merges.
REQ-031 Assert rst asynchronously mid-cycle with pending=8'hFF, valid=1 -> pending=0, valid=0, code=0 before next edge.
